// File: rtl/serial_io_endpoint.sv
// Device-side serial IO endpoint: TX FIFO -> 8N1 UART on txd, host bytes -> RX FIFO -> processor.
// Optional feature macro SERIAL_LOOPBACK_EN adds a loopback port feeding transmitted bytes back into RX.

module serial_io_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr, wr_next, rd_next;
  logic [W-1:0]  mem [DEPTH];
  logic          do_push, do_pop;

  // readiness is the registered flag only; a same-cycle pop never frees a slot early
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign wr_next = wr_ptr + PW'(do_push);
  assign rd_next = rd_ptr + PW'(do_pop);

  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      head   <= '0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      full   <= (wr_next[AW] != rd_next[AW]) && (wr_next[AW-1:0] == rd_next[AW-1:0]);
      empty  <= (wr_next == rd_next);
      // head bypasses the array when the byte being written becomes the new head
      if (wr_next != rd_next)
        head <= (do_push && rd_next == wr_ptr) ? push_data : mem[rd_next[AW-1:0]];
    end
  end
endmodule

module serial_io_endpoint #(
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] serial_out,
  input  logic       serial_wren_out,
  input  logic       serial_rden_out,
  output logic [7:0] serial_in,
  output logic       serial_valid_in,
  output logic       serial_ready_in,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
`ifdef SERIAL_LOOPBACK_EN
  input  logic       loopback,
`endif
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_drop
);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          bit_end, tx_pop;
  logic [7:0]    tx_head, rx_head;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          rx_push;
  logic [7:0]    rx_push_data;

  serial_io_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (serial_wren_out),
    .push_data (serial_out),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

`ifdef SERIAL_LOOPBACK_EN
  assign rx_ready     = ~rx_full & ~loopback;
  assign rx_push      = loopback ? tx_pop  : (rx_valid & rx_ready);
  assign rx_push_data = loopback ? tx_head : rx_data;
`else
  assign rx_ready     = ~rx_full;
  assign rx_push      = rx_valid & rx_ready;
  assign rx_push_data = rx_data;
`endif

  serial_io_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (serial_rden_out),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign serial_in       = rx_head;
  assign serial_valid_in = ~rx_empty;
  assign serial_ready_in = ~tx_full;
  assign tx_busy         = (state != IDLE) | ~tx_empty;

  // the last stop-bit cycle may pop the next byte so frames run back to back
  assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));
  assign tx_pop  = ~tx_empty & ((state == IDLE) | ((state == STOP) & bit_end));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          cnt <= '0;
          if (tx_pop) begin
            shift <= tx_head;
            state <= START;
            txd   <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= DATA;
            txd     <= shift[0];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              txd     <= shift[1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (tx_pop) begin
              shift <= tx_head;
              state <= START;
              txd   <= 1'b0;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                           tx_drop <= 1'b0;
    else if (serial_wren_out && tx_full)  tx_drop <= 1'b1;
  end
endmodule

// File: tb/tb_serial_io_endpoint.sv
// Bench for serial_io_endpoint: frame-timeline / queue model checked every cycle plus literal spot checks.
module tb_serial_io_endpoint;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;

  logic       clock, reset;
  logic [7:0] serial_out, serial_in, rx_data;
  logic       serial_wren_out, serial_rden_out, serial_valid_in, serial_ready_in;
  logic       rx_valid, rx_ready, txd, tx_busy, tx_drop, loopback;

  int n_pass = 0, n_total = 0;

  serial_io_endpoint #(.FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clock           (clock),
    .reset           (reset),
    .serial_out      (serial_out),
    .serial_wren_out (serial_wren_out),
    .serial_rden_out (serial_rden_out),
    .serial_in       (serial_in),
    .serial_valid_in (serial_valid_in),
    .serial_ready_in (serial_ready_in),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
`ifdef SERIAL_LOOPBACK_EN
    .loopback        (loopback),
`endif
    .txd             (txd),
    .tx_busy         (tx_busy),
    .tx_drop         (tx_drop)
  );

  always #5 clock = ~clock;

  // Model: each accepted TX byte gets a frame start cycle; occupancy and txd follow from those times.
  typedef struct { logic [7:0] b; int p; int s; } tx_ent_t;
  tx_ent_t    txq[$];
  logic [7:0] rxq[$];
  logic [7:0] rx_last;
  bit         drop_m;
  int         last_end;
  int         cyc = 0;

  always @(negedge clock) begin
    int occ, sz, st;
    logic txd_e, inframe, lb;
    logic [7:0] lbb;
    logic [9:0] fr;
    logic [13:0] exp_v, act_v;
    cyc++;
    if (!reset) begin
      txq.delete(); rxq.delete();
      rx_last = 8'h00; drop_m = 0; last_end = 0;
    end
    occ = 0; txd_e = 1'b1; inframe = 1'b0;
    foreach (txq[i]) begin
      if (txq[i].p < cyc && txq[i].s - 1 >= cyc) occ++;
      if (cyc >= txq[i].s && cyc < txq[i].s + 10*CPB) begin
        inframe = 1'b1;
        fr = {1'b1, txq[i].b, 1'b0};
        txd_e = fr[(cyc - txq[i].s) / CPB];
      end
    end
    sz = rxq.size();
    exp_v = {txd_e, (inframe || occ > 0), drop_m, (occ < DEPTH),
             (sz < DEPTH && !loopback), (sz > 0), rx_last};
    act_v = {txd, tx_busy, tx_drop, serial_ready_in, rx_ready, serial_valid_in, serial_in};
    n_total++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL model cyc %0d: dut {txd,busy,drop,srdy,rxrdy,vld,din}=%b want %b", cyc, act_v, exp_v);

    if (reset) begin
      lb = 1'b0; lbb = 8'h00;
      if (loopback)
        foreach (txq[i]) if (txq[i].s - 1 == cyc) begin lb = 1'b1; lbb = txq[i].b; end
      if (serial_rden_out && sz > 0) rxq.delete(0);
      if ((loopback ? lb : rx_valid) && sz < DEPTH) rxq.push_back(loopback ? lbb : rx_data);
      if (rxq.size() > 0) rx_last = rxq[0];
      if (serial_wren_out) begin
        if (occ < DEPTH) begin
          st = (last_end > cyc + 2) ? last_end : cyc + 2;
          txq.push_back('{b: serial_out, p: cyc, s: st});
          last_end = st + 10*CPB;
        end else drop_m = 1;
      end
      while (txq.size() > 0 && txq[0].s + 10*CPB <= cyc) txq.delete(0);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  initial begin
    logic [9:0] a5_frame;
    logic [7:0] rx_exp [6];
    a5_frame = {1'b1, 8'hA5, 1'b0};
    rx_exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2};
    clock = 0; reset = 0; serial_out = 0; serial_wren_out = 0; serial_rden_out = 0;
    rx_data = 0; rx_valid = 0; loopback = 0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_txd", {7'd0, txd}, 8'h01);
    check("rst_valid", {7'd0, serial_valid_in}, 8'h00);
    check("rst_ready", {7'd0, serial_ready_in}, 8'h01);
    check("rst_serial_in", serial_in, 8'h00);
    tick(); reset = 1;
    repeat (2) tick();

    // single A5 frame: idle, then start/8 data/stop, 4 cycles each
    serial_out = 8'hA5; serial_wren_out = 1;
    tick(); serial_wren_out = 0;
    @(negedge clock); check("a5_latency", {7'd0, txd}, 8'h01);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock); check("a5_bit", {7'd0, txd}, {7'd0, a5_frame[i/CPB]});
    end
    repeat (3) tick();
    @(negedge clock); check("a5_busy_done", {7'd0, tx_busy}, 8'h00);

    // six writes into a 4-deep FIFO: sixth dropped
    for (int i = 0; i < 6; i++) begin
      tick(); serial_out = 8'(i + 1); serial_wren_out = 1;
      if (i == 5) begin @(negedge clock); check("full_ready", {7'd0, serial_ready_in}, 8'h00); end
    end
    tick(); serial_wren_out = 0;
    @(negedge clock); check("drop_set", {7'd0, tx_drop}, 8'h01);
    repeat (205) tick();
    @(negedge clock);
    check("full_done_busy", {7'd0, tx_busy}, 8'h00);
    check("drop_sticky", {7'd0, tx_drop}, 8'h01);

    // reset mid-frame
    tick(); serial_out = 8'h3C; serial_wren_out = 1;
    tick(); serial_out = 8'hC3;
    tick(); serial_wren_out = 0;
    repeat (10) tick();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("midrst_txd", {7'd0, txd}, 8'h01);
      check("midrst_drop", {7'd0, tx_drop}, 8'h00);
      check("midrst_ready", {7'd0, serial_ready_in}, 8'h01);
      tick();
    end
    reset = 1;
    repeat (50) tick();
    @(negedge clock); check("midrst_lost", {7'd0, tx_busy}, 8'h00);

    // RX ordering
    tick(); rx_data = 8'h11; rx_valid = 1;
    tick(); rx_data = 8'h22;
    tick(); rx_data = 8'h33;
    tick(); rx_valid = 0;
    @(negedge clock); check("rx_head", serial_in, 8'h11);
    check("rx_valid", {7'd0, serial_valid_in}, 8'h01);
    tick(); serial_rden_out = 1;
    @(negedge clock); check("rx_pop0", serial_in, 8'h11);
    tick(); @(negedge clock); check("rx_pop1", serial_in, 8'h22);
    tick(); @(negedge clock); check("rx_pop2", serial_in, 8'h33);
    tick(); serial_rden_out = 0;
    @(negedge clock); check("rx_empty", {7'd0, serial_valid_in}, 8'h00);
    check("rx_hold", serial_in, 8'h33);

    // RX full with simultaneous push+pop
    for (int i = 0; i < 4; i++) begin tick(); rx_data = 8'(8'hA0 + i); rx_valid = 1; end
    tick(); serial_rden_out = 1;
    for (int i = 0; i < 6; i++) begin
      rx_data = 8'(8'hB0 + i);
      @(negedge clock);
      if (i == 0) check("rxfull_ready", {7'd0, rx_ready}, 8'h00);
      check("rxfull_order", serial_in, rx_exp[i]);
      tick();
    end
    rx_valid = 0;
    repeat (5) tick();
    serial_rden_out = 0;
    tick();

`ifdef SERIAL_LOOPBACK_EN
    loopback = 1;
    tick(); serial_out = 8'h5A; serial_wren_out = 1;
    tick(); serial_wren_out = 0;
    for (int i = 0; i < 44; i++) begin
      @(negedge clock); if (i % 10 == 0) check("lb_rx_ready", {7'd0, rx_ready}, 8'h00);
      tick();
    end
    @(negedge clock);
    check("lb_data", serial_in, 8'h5A);
    check("lb_valid", {7'd0, serial_valid_in}, 8'h01);
    tick(); serial_rden_out = 1;
    tick(); serial_rden_out = 0; loopback = 0;
    repeat (3) tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
